// File: rtl/inst_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues requests to a 1-cycle synchronous
// instruction SRAM and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO
// for decode. Branch redirects and exception flushes drop all queued and
// in-flight fetches and restart fetching at the redirect target.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [31:0]      new_pc,
  input  logic             br_e,
  input  logic [31:0]      br_addr,
  output logic             inst_sram_en,
  output logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_rdata,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned    PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic             redirect;
  logic [31:0]      target;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;

  // A flush outranks a simultaneous branch redirect.
  assign redirect = flush | br_e;
  assign target   = flush ? new_pc : br_addr;

  // Credit rule: stored entries plus the outstanding request must leave room,
  // so a returning response always has a free slot. No pop lookahead.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = !rst && !redirect && (occupancy < DEPTH_OCC);

  // A response arriving in a redirect cycle belongs to the abandoned path.
  assign push = inflight && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  assign inst_sram_en   = issue;
  assign inst_sram_addr = fetch_pc;

  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[rd_ptr];
  assign out_inst  = inst_mem[rd_ptr];

  // Fetch PC advance and tracking of the single outstanding SRAM request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples pre-edge values regardless of statement order.
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write of the returning instruction and its PC.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; count and pointers alone decide
    // which entries are valid, so the arrays can map onto plain RAM.
    if (push && !rst) begin
      pc_mem[wr_ptr]   <= inflight_pc;
      inst_mem[wr_ptr] <= inst_sram_rdata;
    end
  end

endmodule
